// File: rtl/mtm_alu_serializer_pkg.sv
// Shared ALU serializer definitions: packet framing constants, FSM state
// encoding, and the helper that selects the payload byte for a packet.
package mtm_alu_serializer_pkg;

    localparam int   PKT_BITS   = 11;
    localparam int   FRAME_PKTS = 5;
    localparam logic TYPE_DATA  = 1'b0;
    localparam logic TYPE_CTL   = 1'b1;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_START = 3'd1;
    localparam logic [2:0] ST_TYPE  = 3'd2;
    localparam logic [2:0] ST_DATA  = 3'd3;
    localparam logic [2:0] ST_STOP  = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE  = ST_IDLE,
        S_START = ST_START,
        S_TYPE  = ST_TYPE,
        S_DATA  = ST_DATA,
        S_STOP  = ST_STOP
    } ser_state_e;

    // Packets 0..3 carry the result MSB byte first; the last packet carries
    // the flags and CRC behind a leading zero bit.
    function automatic logic [7:0] pkt_byte(input logic [2:0]  idx,
                                            input logic [31:0] c,
                                            input logic [3:0]  flg,
                                            input logic [2:0]  crc);
        logic [7:0] b;
        case (idx)
            3'd0:    b = c[31:24];
            3'd1:    b = c[23:16];
            3'd2:    b = c[15:8];
            3'd3:    b = c[7:0];
            default: b = {1'b0, flg, crc};
        endcase
        return b;
    endfunction

endpackage

// File: rtl/mtm_alu_serializer.sv
// ALU result serializer. Captures one result (C, flags, CRC) on a send_data
// strobe while idle and shifts it out as a 5-packet frame on an idle-high
// line. Each packet is: start 0, type bit, 8 data bits MSB first, stop 1.
//
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   send_data  one-cycle strobe, inputs valid
//   C_in       32-bit ALU result
//   flg_in     flags {carry, overflow, zero, negative}
//   crc_in     CRC3 of result and flags
//   sout       registered serial output, idle high
//   busy       high while a frame is on the line
//
// state | meaning
// ------+--------------------------------------------
// IDLE  | line high, waiting for send_data
// START | start bit (0) of current packet
// TYPE  | type bit: 0 for result bytes, 1 for ctl byte
// DATA  | 8 data bits, MSB first
// STOP  | stop bit (1); next packet or back to IDLE
module mtm_alu_serializer
    import mtm_alu_serializer_pkg::*;
#(
    parameter int BIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        send_data,
    input  logic [31:0] C_in,
    input  logic [3:0]  flg_in,
    input  logic [2:0]  crc_in,
    output logic        sout,
    output logic        busy
);

    localparam logic [7:0] CYC_LAST = 8'(BIT_CYCLES - 1);
    localparam logic [2:0] PKT_LAST = 3'(FRAME_PKTS - 1);

    ser_state_e  state_q, state_nxt;
    logic [7:0]  cyc_q, cyc_nxt;
    logic [2:0]  bit_q, bit_nxt;
    logic [2:0]  pkt_q, pkt_nxt;
    logic [31:0] c_q, c_nxt;
    logic [3:0]  flg_q, flg_nxt;
    logic [2:0]  crc_q, crc_nxt;
    logic [7:0]  shift_q, shift_nxt;
    logic        sout_q, sout_nxt;
    logic        bit_end;

    assign bit_end = (cyc_q == CYC_LAST);
    assign sout    = sout_q;
    assign busy    = (state_q != S_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cyc_q   <= '0;
            bit_q   <= '0;
            pkt_q   <= '0;
            c_q     <= '0;
            flg_q   <= '0;
            crc_q   <= '0;
            shift_q <= '0;
            sout_q  <= 1'b1;
        end else begin
            state_q <= state_nxt;
            cyc_q   <= cyc_nxt;
            bit_q   <= bit_nxt;
            pkt_q   <= pkt_nxt;
            c_q     <= c_nxt;
            flg_q   <= flg_nxt;
            crc_q   <= crc_nxt;
            shift_q <= shift_nxt;
            sout_q  <= sout_nxt;
        end
    end

    // sout_nxt is the value of the bit that starts on the next edge, so the
    // line changes exactly at bit boundaries and stays registered.
    always_comb begin
        state_nxt = state_q;
        cyc_nxt   = cyc_q;
        bit_nxt   = bit_q;
        pkt_nxt   = pkt_q;
        c_nxt     = c_q;
        flg_nxt   = flg_q;
        crc_nxt   = crc_q;
        shift_nxt = shift_q;
        sout_nxt  = sout_q;

        if (state_q != S_IDLE) begin
            cyc_nxt = bit_end ? 8'd0 : cyc_q + 8'd1;
        end

        case (state_q)
            S_IDLE: begin
                sout_nxt = 1'b1;
                cyc_nxt  = '0;
                bit_nxt  = '0;
                pkt_nxt  = '0;
                if (send_data) begin
                    c_nxt     = C_in;
                    flg_nxt   = flg_in;
                    crc_nxt   = crc_in;
                    state_nxt = S_START;
                    sout_nxt  = 1'b0;
                end
            end
            S_START: begin
                if (bit_end) begin
                    state_nxt = S_TYPE;
                    sout_nxt  = (pkt_q == PKT_LAST) ? TYPE_CTL : TYPE_DATA;
                    shift_nxt = pkt_byte(pkt_q, c_q, flg_q, crc_q);
                end
            end
            S_TYPE: begin
                if (bit_end) begin
                    state_nxt = S_DATA;
                    sout_nxt  = shift_q[7];
                    shift_nxt = {shift_q[6:0], 1'b0};
                    bit_nxt   = '0;
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    if (bit_q == 3'd7) begin
                        state_nxt = S_STOP;
                        sout_nxt  = 1'b1;
                        bit_nxt   = '0;
                    end else begin
                        sout_nxt  = shift_q[7];
                        shift_nxt = {shift_q[6:0], 1'b0};
                        bit_nxt   = bit_q + 3'd1;
                    end
                end
            end
            S_STOP: begin
                if (bit_end) begin
                    if (pkt_q == PKT_LAST) begin
                        state_nxt = S_IDLE;
                        sout_nxt  = 1'b1;
                        pkt_nxt   = '0;
                    end else begin
                        state_nxt = S_START;
                        sout_nxt  = 1'b0;
                        pkt_nxt   = pkt_q + 3'd1;
                    end
                end
            end
            default: begin
                state_nxt = S_IDLE;
                sout_nxt  = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_mtm_alu_serializer.sv
// Scoreboard bench for mtm_alu_serializer: two instances (BIT_CYCLES 1 and 4),
// a frame-level reference model feeding expected frames into queues, and a
// line decoder per instance that pops and compares.
module tb_mtm_alu_serializer;
    import mtm_alu_serializer_pkg::*;

    localparam int BC0 = 1;
    localparam int BC1 = 4;
    localparam int FRAME_BITS = PKT_BITS * FRAME_PKTS;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]  rst_v;
    logic [1:0]  sd_v;
    logic [31:0] c_v   [2];
    logic [3:0]  flg_v [2];
    logic [2:0]  crc_v [2];
    wire  [1:0]  sout_v;
    wire  [1:0]  busy_v;

    mtm_alu_serializer #(.BIT_CYCLES(BC0)) u_dut0 (
        .clk(clk), .rst(rst_v[0]), .send_data(sd_v[0]), .C_in(c_v[0]),
        .flg_in(flg_v[0]), .crc_in(crc_v[0]), .sout(sout_v[0]), .busy(busy_v[0])
    );

    mtm_alu_serializer #(.BIT_CYCLES(BC1)) u_dut1 (
        .clk(clk), .rst(rst_v[1]), .send_data(sd_v[1]), .C_in(c_v[1]),
        .flg_in(flg_v[1]), .crc_in(crc_v[1]), .sout(sout_v[1]), .busy(busy_v[1])
    );

    typedef struct {
        logic [54:0] bits;
        longint      start;
    } frame_t;

    frame_t exp0[$];
    frame_t exp1[$];

    longint cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int     checks = 0;
    int     failures = 0;
    bit     abort_pending [2];
    longint fstart [2];
    int     bcs [2];

    task automatic check_eq(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Line image of a frame, bit i = i-th bit on the wire.
    function automatic logic [54:0] frame_bits(input logic [31:0] c, input logic [3:0] f,
                                               input logic [2:0] cr);
        logic [39:0] payload;
        logic [54:0] v;
        logic [7:0]  b;
        payload = {c, 1'b0, f, cr};
        v = '0;
        for (int p = 0; p < FRAME_PKTS; p++) begin
            b = payload[39 - 8*p -: 8];
            v[p*PKT_BITS]     = 1'b0;
            v[p*PKT_BITS + 1] = (p == FRAME_PKTS - 1) ? TYPE_CTL : TYPE_DATA;
            for (int j = 0; j < 8; j++) v[p*PKT_BITS + 2 + j] = b[7 - j];
            v[p*PKT_BITS + 10] = 1'b1;
        end
        return v;
    endfunction

    function automatic bit model_busy(input int k, input longint t);
        return fstart[k] >= 0 && t >= fstart[k] && t < fstart[k] + longint'(FRAME_BITS * bcs[k]);
    endfunction

    function automatic int qsize(input int k);
        return (k == 0) ? exp0.size() : exp1.size();
    endfunction

    // One negedge-to-negedge step of stimulus for instance k; the model
    // decides what the upcoming edge does to the line.
    task automatic cycle(input int k, input bit r, input bit sd, input logic [31:0] c,
                         input logic [3:0] f, input logic [2:0] cr);
        longint now;
        frame_t e;
        now = cyc;
        rst_v[k] = r;
        sd_v[k]  = sd;
        c_v[k]   = c;
        flg_v[k] = f;
        crc_v[k] = cr;
        if (r) begin
            if (model_busy(k, now + 1)) abort_pending[k] = 1'b1;
            fstart[k] = -1;
        end else if (sd && !model_busy(k, now)) begin
            e.bits  = frame_bits(c, f, cr);
            e.start = now + 1;
            if (k == 0) exp0.push_back(e); else exp1.push_back(e);
            fstart[k] = now + 1;
        end
        @(negedge clk);
    endtask

    task automatic idle(input int k, input int n);
        repeat (n) cycle(k, 1'b0, 1'b0, $urandom(), 4'($urandom()), 3'($urandom()));
    endtask

    task automatic send(input int k, input logic [31:0] c, input logic [3:0] f, input logic [2:0] cr);
        cycle(k, 1'b0, 1'b1, c, f, cr);
    endtask

    task automatic monitor(input int k, input int bc);
        bit          in_f = 1'b0;
        bit          have_exp = 1'b0;
        bit          hold_bad = 1'b0;
        int          n = 0;
        logic [54:0] got = '0;
        frame_t      e;
        logic        s, b;
        forever begin
            @(negedge clk);
            s = sout_v[k];
            b = busy_v[k];
            if (!in_f) begin
                if (s === 1'b0) begin
                    in_f = 1'b1;
                    n = 1;
                    hold_bad = 1'b0;
                    got = '0;
                    check_eq($sformatf("busy_rise_i%0d", k), b, 1);
                    check_eq($sformatf("frame_expected_i%0d", k), 64'(qsize(k) > 0), 1);
                    have_exp = (qsize(k) > 0);
                    if (have_exp) begin
                        e = (k == 0) ? exp0.pop_front() : exp1.pop_front();
                        check_eq($sformatf("start_cycle_i%0d", k), cyc, e.start);
                    end
                end else begin
                    check_eq($sformatf("idle_sout_i%0d", k), s, 1);
                    check_eq($sformatf("idle_busy_i%0d", k), b, 0);
                end
            end else if (b !== 1'b1) begin
                check_eq($sformatf("busy_drop_without_reset_i%0d", k), abort_pending[k], 1);
                check_eq($sformatf("abort_sout_i%0d", k), s, 1);
                abort_pending[k] = 1'b0;
                in_f = 1'b0;
            end else begin
                if (n % bc == 0) got[n / bc] = s;
                else if (s !== got[n / bc]) hold_bad = 1'b1;
                n++;
                if (n == FRAME_BITS * bc) begin
                    in_f = 1'b0;
                    check_eq($sformatf("bit_hold_i%0d", k), hold_bad, 0);
                    if (have_exp) begin
                        for (int p = 0; p < FRAME_PKTS; p++)
                            check_eq($sformatf("pkt%0d_i%0d", p, k),
                                     got[p*PKT_BITS +: PKT_BITS], e.bits[p*PKT_BITS +: PKT_BITS]);
                    end
                end
            end
        end
    endtask

    initial begin
        bcs[0] = BC0;
        bcs[1] = BC1;
        fstart[0] = -1;
        fstart[1] = -1;
        abort_pending[0] = 1'b0;
        abort_pending[1] = 1'b0;
        rst_v = 2'b11;
        sd_v  = 2'b11;   // strobes during reset must not start anything
        for (int i = 0; i < 2; i++) begin
            c_v[i] = 32'hDEADBEEF; flg_v[i] = 4'hF; crc_v[i] = 3'h7;
        end
        repeat (3) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            check_eq($sformatf("reset_sout_i%0d", i), sout_v[i], 1);
            check_eq($sformatf("reset_busy_i%0d", i), busy_v[i], 0);
        end
        fork
            monitor(0, BC0);
            monitor(1, BC1);
        join_none
        rst_v[1] = 1'b0;
        sd_v[1]  = 1'b0;

        // Instance 0, one cycle per bit. First accept right after reset.
        send(0, 32'h12345678, 4'b0010, 3'b011);
        idle(0, 60);

        // Strobe mid-frame is ignored.
        send(0, 32'hA5C3_0F81, 4'b1001, 3'b101);
        idle(0, 20);
        send(0, 32'hFFFFFFFF, 4'hF, 3'h7);
        idle(0, 80);

        // send_data held through a whole frame: back-to-back frames.
        repeat (57) cycle(0, 1'b0, 1'b1, $urandom(), 4'($urandom()), 3'($urandom()));
        idle(0, 70);

        // Reset mid-frame, then an immediate new result.
        send(0, 32'hCAFEF00D, 4'b0101, 3'b110);
        idle(0, 29);
        cycle(0, 1'b1, 1'b1, 32'h11111111, 4'h1, 3'h1);
        send(0, 32'h87654321, 4'b1100, 3'b010);
        idle(0, 70);

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 1500; i++)
            cycle(0, $urandom_range(0, 199) == 0, $urandom_range(0, 7) == 0,
                  $urandom(), 4'($urandom()), 3'($urandom()));
        idle(0, 70);

        // Instance 1, four cycles per bit.
        send(1, 32'h00000000, 4'b0010, 3'b000);
        idle(1, 240);
        send(1, 32'h0F1E2D3C, 4'b0110, 3'b001);
        idle(1, 70);
        cycle(1, 1'b1, 1'b0, 32'h0, 4'h0, 3'h0);
        send(1, 32'hB00B1E5, 4'b1000, 3'b111);
        idle(1, 240);
        for (int i = 0; i < 2500; i++)
            cycle(1, $urandom_range(0, 399) == 0, $urandom_range(0, 15) == 0,
                  $urandom(), 4'($urandom()), 3'($urandom()));
        idle(1, 240);

        for (int i = 0; i < 2; i++) begin
            check_eq($sformatf("frames_outstanding_i%0d", i), 64'(qsize(i)), 0);
            check_eq($sformatf("abort_not_seen_i%0d", i), abort_pending[i], 0);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mtm_alu_serializer.md
MTM_ALU_SERIALIZER -- requirements
Module: mtm_alu_serializer

Interface
REQ-001 The block SHALL have one parameter: BIT_CYCLES, default 1, clock cycles per serial bit (legal range 1..255).
REQ-002 clk  input  1  single system clock; all logic SHALL be clocked on its rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 send_data  input  1  one-cycle strobe from the ALU core marking C_in/flg_in/crc_in valid.
REQ-005 C_in  input  32  ALU result.
REQ-006 flg_in  input  4  flags {carry, overflow, zero, negative}.
REQ-007 crc_in  input  3  CRC3 over result and flags, computed by the core.
REQ-008 sout  output  1  serial line, registered, idle-high.
REQ-009 busy  output  1  high while a frame is being transmitted.

Function
REQ-010 The block SHALL accept a result only when send_data=1 and busy=0, capturing C_in, flg_in and crc_in into internal registers on that edge.
REQ-011 send_data asserted while busy=1 SHALL be ignored, with no effect on the frame in progress and no queuing.
REQ-012 An accepted result SHALL be sent as one frame of 5 packets, each packet 11 bits: start bit 0, type bit, 8 data bits MSB first, stop bit 1.
REQ-013 Packets 0..3 SHALL carry type 0 and data C[31:24], C[23:16], C[15:8], C[7:0], in that order.
REQ-014 Packet 4 SHALL carry type 1 and data {1'b0, flg[3:0], crc[2:0]}.
REQ-015 Each bit SHALL be held on sout for exactly BIT_CYCLES cycles; a frame SHALL occupy exactly 55*BIT_CYCLES cycles, with packets back-to-back and no idle gap between them.
REQ-016 Latency: the first start bit SHALL appear on sout in the cycle after the accepting edge.
REQ-017 busy SHALL rise in the same cycle as the first start bit and fall in the cycle after the final stop bit's last cycle.
REQ-018 A send_data strobe arriving in the first cycle with busy=0 after a frame SHALL be accepted, so the minimum frame-to-frame spacing is 55*BIT_CYCLES+1 cycles.
REQ-019 The state machine SHALL have states IDLE, START, TYPE, DATA and STOP, with these transitions:
- IDLE->START on accept;
- START->TYPE, TYPE->DATA, and DATA->STOP after bit 7, each after BIT_CYCLES cycles;
- STOP->START if the packet index is below 4, else STOP->IDLE.
REQ-020 The counters SHALL be:
- cycle counter 0..BIT_CYCLES-1, wrapping to 0 at each bit boundary;
- bit index 0..7;
- packet index 0..4.
Every counter SHALL return to 0 in IDLE.
REQ-021 In IDLE, sout SHALL be 1.
REQ-022 Captured data SHALL stay stable for the whole frame regardless of input changes.

Reset
REQ-023 When rst=1 at a clock edge, the following SHALL apply on the next cycle:
- sout=1, busy=0;
- state IDLE;
- all counters and capture registers 0.
REQ-024 Reset mid-frame SHALL abandon the frame immediately, with no completion of the current packet.
REQ-025 send_data coincident with rst=1 SHALL be ignored.
REQ-026 The first accept SHALL be possible in the first cycle after rst deasserts.

Structure
REQ-027 The following SHALL live in the shared ALU package:
- packet constants: PKT_BITS=11, FRAME_PKTS=5, TYPE_DATA=0, TYPE_CTL=1;
- state encoding localparams.
REQ-028 The block SHALL be a single module with no sub-modules; the 8-bit packet shift register SHALL be inline.

Verification
REQ-029 BIT_CYCLES=1; C_in=0x12345678, flg_in=4'b0010, crc_in=3'b011, one send_data pulse -> bytes 0x12,0x34,0x56,0x78 sent with type 0 and 0x13 sent with type 1; busy high for exactly 55 cycles; sout=1 afterwards.
REQ-030 BIT_CYCLES=4; C_in=0x00000000, flg_in=4'b0010, crc_in=3'b000 -> every bit held 4 cycles; frame length 220 cycles; CTL byte 0x10.
REQ-031 A second send_data, C_in=0xFFFFFFFF, issued at frame cycle 20 -> ignored; the frame still carries the first result; no second frame follows.
REQ-032 send_data held for the entire frame plus 1 cycle -> the next frame starts exactly 1 cycle after busy falls.
REQ-033 rst=1 at frame cycle 30 -> sout=1 and busy=0 on the next cycle; a new result sent 1 cycle after rst deasserts is transmitted correctly.
REQ-034 Both frames SHALL be captured by a bench decoder that checks start/stop bits, type bits and byte order, with zero mismatches.
